// File: rtl/alu_muldiv_seq.sv
// Sequential 64-bit unsigned multiplier / divider built around an external
// add/sub ALU. MUL is shift-and-add and DIVU is restoring division. Each
// operation always takes 64 iterations, followed by a single DONE cycle.
//
// Handshake: start is sampled only in IDLE. When it is accepted, op, rs1 and
// rs2 are captured and busy rises in the following cycle. busy stays high for
// exactly 64 cycles. done then pulses for one cycle, and result/remainder are
// already valid in that cycle. The block is back in IDLE in the cycle after
// done. start, op, rs1 and rs2 are don't-care while busy or done is high.
module alu_muldiv_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] remainder,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_sel,
  output logic            alu_sub,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_carry
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Shared working registers:
  //   acc_rem : MUL accumulator  / DIV partial remainder
  //   mc_quot : MUL multiplicand / DIV dividend shifting into quotient
  //   mp_dvsr : MUL multiplier   / DIV divisor
  logic [XLEN-1:0] acc_rem_q, acc_rem_d;
  logic [XLEN-1:0] mc_quot_q, mc_quot_d;
  logic [XLEN-1:0] mp_dvsr_q, mp_dvsr_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] rem_q, rem_d;

  logic [XLEN-1:0] shifted;
  logic            last_iter;

  // The remainder shifted left by one, with the next dividend bit brought in.
  assign shifted   = {acc_rem_q[XLEN-2:0], mc_quot_q[XLEN-1]};
  assign last_iter = (cnt_q == 6'd63);

  // Next-state logic and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = op ? S_DIV : S_MUL;
      end
      S_MUL: begin
        busy = 1'b1;
        if (last_iter) state_d = S_DONE;
      end
      S_DIV: begin
        busy = 1'b1;
        if (last_iter) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: ALU operand steering, iteration updates and result capture.
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_sub   = 1'b0;
    acc_rem_d = acc_rem_q;
    mc_quot_d = mc_quot_q;
    mp_dvsr_d = mp_dvsr_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    rem_d     = rem_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // MUL and DIV share the same initial loading pattern.
          acc_rem_d = '0;
          mc_quot_d = rs1;
          mp_dvsr_d = rs2;
          cnt_d     = 6'd0;
        end
      end
      S_MUL: begin
        alu_a     = acc_rem_q;
        alu_b     = mc_quot_q;
        acc_rem_d = mp_dvsr_q[0] ? alu_out : acc_rem_q;
        mc_quot_d = {mc_quot_q[XLEN-2:0], 1'b0};
        mp_dvsr_d = {1'b0, mp_dvsr_q[XLEN-1:1]};
        cnt_d     = cnt_q + 6'd1;
        if (last_iter) begin
          result_d = acc_rem_d;
          rem_d    = '0;
        end
      end
      S_DIV: begin
        // The ALU carry gives shifted >= divisor, which is the quotient bit.
        alu_a     = shifted;
        alu_b     = mp_dvsr_q;
        alu_sub   = 1'b1;
        acc_rem_d = alu_carry ? alu_out : shifted;
        mc_quot_d = {mc_quot_q[XLEN-2:0], alu_carry};
        cnt_d     = cnt_q + 6'd1;
        if (last_iter) begin
          result_d = mc_quot_d;
          rem_d    = acc_rem_d;
        end
      end
      default: begin
        cnt_d = 6'd0;
      end
    endcase
  end

  assign alu_sel   = 3'b000;
  assign result    = result_q;
  assign remainder = rem_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Working registers, iteration counter and held outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_rem_q <= '0;
      mc_quot_q <= '0;
      mp_dvsr_q <= '0;
      cnt_q     <= 6'd0;
      result_q  <= '0;
      rem_q     <= '0;
    end else begin
      acc_rem_q <= acc_rem_d;
      mc_quot_q <= mc_quot_d;
      mp_dvsr_q <= mp_dvsr_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      rem_q     <= rem_d;
    end
  end

endmodule

// File: doc/alu_muldiv_seq.md
ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq
Interface
REQ-001 Parameter XLEN, default 64: operand/result width; only 64 is supported; iteration counter is 6 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  1  0 = MUL (low 64 bits of unsigned product), 1 = DIVU (unsigned divide).
REQ-006 rs1  input  64  multiplicand / dividend; latched when start is accepted.
REQ-007 rs2  input  64  multiplier / divisor; latched when start is accepted.
REQ-008 busy  output  1  high during the 64 iteration cycles.
REQ-009 done  output  1  one-cycle pulse; result and remainder are valid in that cycle.
REQ-010 result  output  64  MUL product (low 64 bits) or DIVU quotient; held until the next accepted start or reset.
REQ-011 remainder  output  64  DIVU remainder; 0 after MUL; held like result.
REQ-012 alu_a  output  64  A operand to the shared ALU.
REQ-013 alu_b  output  64  B operand to the shared ALU.
REQ-014 alu_sel  output  3  ALU select; always 3'b000 (add/sub).
REQ-015 alu_sub  output  1  ALU subtract enable (B inverted, carry-in 1).
REQ-016 alu_out  input  64  ALU sum, combinational from alu_a/alu_b/alu_sub in the same cycle.
REQ-017 alu_carry  input  1  ALU carry-out; with alu_sub=1, it is 1 iff alu_a >= alu_b (unsigned).
Function
REQ-018 FSM states: IDLE, MUL, DIV, DONE.
REQ-019 IDLE transitions: start=1 goes to MUL (op=0) or DIV (op=1) and latches rs1/rs2; the counter is cleared.
REQ-020 IDLE otherwise stays in IDLE.
REQ-021 start and op are ignored in MUL, DIV and DONE; later changes to rs1/rs2 have no effect on an operation in flight.
REQ-022 MUL operands: alu_a = acc, alu_b = mcand, alu_sub = 0.
REQ-023 MUL iteration: if mplier[0]=1 then acc <= alu_out; mcand <<= 1 (bit 63 discarded); mplier >>= 1.
REQ-024 MUL initial values: acc = 0, mcand = rs1, mplier = rs2.
REQ-025 DIV shifted value: shifted = {rem[62:0], quot[63]}.
REQ-026 DIV operands: alu_a = shifted, alu_b = divisor, alu_sub = 1; qbit = alu_carry.
REQ-027 DIV update: rem <= qbit ? alu_out : shifted; quot <= {quot[62:0], qbit}.
REQ-028 DIV initial values: rem = 0, quot = rs1, divisor = rs2.
REQ-029 Each MUL/DIV state runs exactly 64 iterations (counter 0..63, no early exit); on the edge where counter=63 it moves to DONE.
REQ-030 DONE lasts one cycle: done=1, result/remainder updated and visible, then the FSM returns to IDLE.
REQ-031 Timing: with start accepted in cycle 0, busy is high in cycles 1-64, done is high in cycle 65 only, and a new start is accepted in cycle 66 or later.
REQ-032 Divide by zero runs the normal 64 cycles and returns quotient 0xFFFF_FFFF_FFFF_FFFF and remainder = dividend.
REQ-033 MUL overflow wraps modulo 2^64.
REQ-034 Outside MUL/DIV, alu_a = 0, alu_b = 0, alu_sub = 0, alu_sel = 3'b000.
Reset
REQ-035 When reset is sampled high the FSM goes to IDLE, and in the following cycle busy=0, done=0, result=0, remainder=0, and all internal registers and the counter are 0.
REQ-036 Reset asserted mid-operation aborts the operation with no done pulse.
REQ-037 Reset has priority over start in the same cycle.
Verification
REQ-038 MUL rs1=0xF, rs2=0x3, start in cycle 0 -> busy in cycles 1-64, done in cycle 65, result=0x2D, remainder=0.
REQ-039 MUL rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=2 -> result=0xFFFF_FFFF_FFFF_FFFE (wrap).
REQ-040 DIVU rs1=0xF, rs2=0x3 -> result=5, remainder=0; DIVU rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=0xC000_0000_0000_0000 -> result=1, remainder=0x3FFF_FFFF_FFFF_FFFF.
REQ-041 DIVU rs1=0x1234, rs2=0 -> result=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234, done in cycle 65.
REQ-042 MUL 7x6 started in cycle 0, then start=1/op=1/rs1=rs2=0 in cycles 10 and 65 -> result=42 in cycle 65, no second operation starts, and busy=0 in cycle 66.
REQ-043 Reset in cycle 30 of a MUL -> cycle 31 has busy=0, done=0, result=0; a MUL 2x3 started in cycle 32 gives done in cycle 97 with result=6.
